// File: rtl/usb_pkg.sv
// Shared USB controller definitions: OUT-transaction FSM states, default
// timeout/retry limits and the PID codes used by the packet sender/receiver.
package usb_pkg;

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        WAIT_SEND_OUT  = 2'd1,
        WAIT_SEND_DATA = 2'd2,
        WAIT_RESPONSE  = 2'd3
    } out_state_t;

    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int DEF_MAX_RETRIES    = 8;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

endpackage

// File: rtl/trans_counter.sv
// Up-counter with synchronous clear (dominant) and increment; async reset to 0.
module trans_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/out_trans.sv
// Host OUT transaction engine: OUT token + DATA0, then ACK/NAK/timeout handling
// with independent NAK and timeout retry limits. OUT_TRANS_STATS_EN adds `attempts`.
module out_trans
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] data_in,
    output logic        sending,
    output logic        done,
    output logic        success,
    output logic        failure,
    input  logic        sent,
    output logic        send_OUT,
    output logic        send_DATA0,
    output logic [63:0] data_out,
    input  logic        rec_start,
    input  logic        rec_ACK,
`ifdef OUT_TRANS_STATS_EN
    input  logic        rec_NAK,
    output logic [3:0]  attempts
`else
    input  logic        rec_NAK
`endif
);

    localparam logic [7:0] TO_LIMIT   = TIMEOUT_CYCLES[7:0];
    localparam logic [3:0] RETRY_LAST = 4'(MAX_RETRIES - 1);

    out_state_t  state_q, state_d;
    logic [63:0] data_q, data_d;

    logic        clk_clr, clk_inc, nak_clr, nak_inc, to_clr, to_inc;
    logic [7:0]  clk_cnt;
    logic [3:0]  nak_cnt;
    logic [3:0]  to_cnt;

    trans_counter #(.W(8)) u_clk_cnt (
        .clock (clock), .reset (reset), .clr (clk_clr), .inc (clk_inc), .count (clk_cnt)
    );
    trans_counter #(.W(4)) u_nak_cnt (
        .clock (clock), .reset (reset), .clr (nak_clr), .inc (nak_inc), .count (nak_cnt)
    );
    trans_counter #(.W(4)) u_to_cnt (
        .clock (clock), .reset (reset), .clr (to_clr), .inc (to_inc), .count (to_cnt)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        sending    = 1'b0;
        done       = 1'b0;
        success    = 1'b0;
        failure    = 1'b0;
        send_OUT   = 1'b0;
        send_DATA0 = 1'b0;
        clk_clr    = 1'b0;
        clk_inc    = 1'b0;
        nak_clr    = 1'b0;
        nak_inc    = 1'b0;
        to_clr     = 1'b0;
        to_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d   = data_in;
                    clk_clr  = 1'b1;
                    nak_clr  = 1'b1;
                    to_clr   = 1'b1;
                    send_OUT = 1'b1;
                    state_d  = WAIT_SEND_OUT;
                end
            end
            WAIT_SEND_OUT: begin
                if (sent) begin
                    send_DATA0 = 1'b1;
                    state_d    = WAIT_SEND_DATA;
                end else begin
                    sending = 1'b1;
                end
            end
            WAIT_SEND_DATA: begin
                if (sent) begin
                    clk_clr = 1'b1;
                    state_d = WAIT_RESPONSE;
                end else begin
                    sending = 1'b1;
                end
            end
            WAIT_RESPONSE: begin
                if (rec_ACK) begin
                    done    = 1'b1;
                    success = 1'b1;
                    state_d = IDLE;
                end else if (rec_NAK) begin
                    if (nak_cnt == RETRY_LAST) begin
                        done    = 1'b1;
                        failure = 1'b1;
                        state_d = IDLE;
                    end else begin
                        nak_inc  = 1'b1;
                        send_OUT = 1'b1;
                        state_d  = WAIT_SEND_OUT;
                    end
                end else if (rec_start) begin
                    // An arriving packet suspends the response timeout.
                    clk_clr = 1'b1;
                end else if (clk_cnt == TO_LIMIT) begin
                    if (to_cnt == RETRY_LAST) begin
                        done    = 1'b1;
                        failure = 1'b1;
                        state_d = IDLE;
                    end else begin
                        to_inc   = 1'b1;
                        clk_clr  = 1'b1;
                        send_OUT = 1'b1;
                        state_d  = WAIT_SEND_OUT;
                    end
                end else begin
                    clk_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign data_out = data_q;

`ifdef OUT_TRANS_STATS_EN
    assign attempts = nak_cnt + to_cnt;
`endif

endmodule
